edge_stim_gen: RTL

EDGE_STIM_GEN -- requirements
Module: edge_stim_gen

---
 rtl/edge_stim_gen.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/edge_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : edge_stim_gen
// Description : Generates a programmable high/low stimulus waveform with a
//               matching enable, for driving an edge checker. Each sequence
//               is rep_cnt pairs of phases, then a one-cycle done pulse.
//               Optional macro EDGE_STIM_EXPECT_EN adds exp_fell/exp_rise,
//               predicting what a two-stage edge checker reports.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_stim_gen #(
    parameter int CNT_W = 8,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic             init_lvl,
    output logic             busy,
    output logic             done,
    output logic             signal_out,
    output logic             en_out,
    output logic             exp_fell,
    output logic             exp_rise
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PHASE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_hi_m1;    // high phase length minus one
    logic [CNT_W-1:0] r_lo_m1;    // low phase length minus one
    logic [REP_W-1:0] r_rep;      // phase pairs remaining, including current
    logic [CNT_W-1:0] r_cnt;      // cycles remaining in current phase minus one
    logic             r_second;   // current phase is the second of its pair
    logic             r_sig;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_hi_m1_nxt;
    logic [CNT_W-1:0] w_lo_m1_nxt;
    logic [REP_W-1:0] w_rep_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_second_nxt;
    logic             w_sig_nxt;

    // Zero lengths/counts behave as one; storing length-1 lets the maximum
    // length fit the counter exactly.
    logic [CNT_W-1:0] w_hi_m1_in;
    logic [CNT_W-1:0] w_lo_m1_in;
    logic [REP_W-1:0] w_rep_in;

    assign w_hi_m1_in = (high_len == '0) ? '0 : high_len - CNT_W'(1);
    assign w_lo_m1_in = (low_len == '0) ? '0 : low_len - CNT_W'(1);
    assign w_rep_in   = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;

    // Next-state and datapath decisions for the sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_hi_m1_nxt  = r_hi_m1;
        w_lo_m1_nxt  = r_lo_m1;
        w_rep_nxt    = r_rep;
        w_cnt_nxt    = r_cnt;
        w_second_nxt = r_second;
        w_sig_nxt    = r_sig;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt  = ST_PHASE;
                    w_hi_m1_nxt  = w_hi_m1_in;
                    w_lo_m1_nxt  = w_lo_m1_in;
                    w_rep_nxt    = w_rep_in;
                    w_cnt_nxt    = init_lvl ? w_hi_m1_in : w_lo_m1_in;
                    w_second_nxt = 1'b0;
                    w_sig_nxt    = init_lvl;
                end
            end
            ST_PHASE: begin
                if (r_cnt == '0) begin
                    if (r_second && (r_rep == REP_W'(1))) begin
                        // Last cycle of the last phase; level is held.
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_sig_nxt    = ~r_sig;
                        w_cnt_nxt    = r_sig ? r_lo_m1 : r_hi_m1;
                        w_second_nxt = ~r_second;
                        if (r_second) begin
                            w_rep_nxt = r_rep - REP_W'(1);
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_hi_m1  <= '0;
            r_lo_m1  <= '0;
            r_rep    <= '0;
            r_cnt    <= '0;
            r_second <= 1'b0;
            r_sig    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hi_m1  <= w_hi_m1_nxt;
            r_lo_m1  <= w_lo_m1_nxt;
            r_rep    <= w_rep_nxt;
            r_cnt    <= w_cnt_nxt;
            r_second <= w_second_nxt;
            r_sig    <= w_sig_nxt;
            r_busy   <= (w_state_nxt == ST_PHASE);
            r_done   <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy       = r_busy;
    assign en_out     = r_busy;
    assign done       = r_done;
    assign signal_out = r_sig;

`ifdef EDGE_STIM_EXPECT_EN
    logic r_sig_d1;
    logic r_en_d1;
    logic r_exp_fell;
    logic r_exp_rise;

    // Model of a checker that compares the level one cycle back with the
    // current level, gated by the enable one cycle back, and registers it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_d1   <= 1'b0;
            r_en_d1    <= 1'b0;
            r_exp_fell <= 1'b0;
            r_exp_rise <= 1'b0;
        end else begin
            r_sig_d1   <= r_sig;
            r_en_d1    <= r_busy;
            r_exp_fell <= r_sig_d1 & ~r_sig & r_en_d1;
            r_exp_rise <= ~r_sig_d1 & r_sig & r_en_d1;
        end
    end

    assign exp_fell = r_exp_fell;
    assign exp_rise = r_exp_rise;
`else
    assign exp_fell = 1'b0;
    assign exp_rise = 1'b0;
`endif

endmodule
`default_nettype wire
